// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0 -- presented downstream whenever no instruction is held.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: redirect target (word aligned) wins over
// the sequential +4 advance; the increment wraps at 2^PC_WIDTH.
module if_pc_reg
  import if_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                advance,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Next pc: aligned redirect target, else pc+4 on a consumed fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~PC_WIDTH'(3);
    end else if (advance) begin
      pc_d = pc_q + PC_WIDTH'(4);
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding request at a time to the
// instruction memory and buffers the returned instruction for IF/ID.
module if_stage
  import if_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic                  valid_out
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSN);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] ins_q, ins_d;
  logic [PC_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic [PC_WIDTH-1:0]   pc_plus4_q, pc_plus4_d;
  logic                  valid_q, valid_d;

  logic [PC_WIDTH-1:0]   pc;
  logic                  buf_free;
  logic                  req_c;
  logic                  accept_c;

  // The buffer can take a new instruction if empty or drained this cycle.
  assign buf_free = !valid_q || !stall;

  if_pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (accept_c),
    .pc          (pc)
  );

  // FSM next state, request generation and response acceptance.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    req_c    = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        req_c = !redirect && buf_free;
        if (req_c && imem_gnt) begin
          req_pc_d = pc;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // A response arriving with the redirect is simply dropped; otherwise
          // the stale response is still in flight and must be drained.
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          accept_c = 1'b1;
          state_d  = REQ;
        end
      end
      DRAIN: begin
        // The in-flight response closes the drain even if another redirect
        // lands in the same cycle; the pc register already took the new target.
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output buffer: load on accepted response, empty on redirect or consume.
  always_comb begin
    ins_d      = ins_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (accept_c) begin
      ins_d      = imem_rdata;
      pc_out_d   = req_pc_q;
      pc_plus4_d = req_pc_q + PC_WIDTH'(4);
      valid_d    = 1'b1;
    end else if (redirect || (valid_q && !stall)) begin
      ins_d   = NOP;
      valid_d = 1'b0;
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_pc_q   <= '0;
      ins_q      <= NOP;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      ins_q      <= ins_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req     = req_c;
  assign imem_addr    = pc;
  assign ins_out      = ins_q;
  assign pc_out       = pc_out_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pc, one "request in flight" flag, one "stale response
  // to throw away" flag, and the output buffer contents.
  logic [31:0] m_pc, m_reqpc, m_ins, m_pco, m_pc4;
  logic        m_valid, m_busy, m_drop, m_started;

  // Bench-side memory: one pending read with a countdown.
  logic        mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lat;    // 0 = random latency 1..3
  logic        exp_req;

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ins_out      (ins_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .valid_out    (valid_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_reqpc = '0; m_ins = NOP; m_pco = '0; m_pc4 = '0;
    m_valid = 1'b0; m_busy = 1'b0; m_drop = 1'b0; m_started = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_valid"}, {31'b0, valid_out}, {31'b0, m_valid});
    check({pfx, "_ins"},   ins_out,      m_ins);
    check({pfx, "_pcout"}, pc_out,       m_pco);
    check({pfx, "_pc4"},   pc_plus4_out, m_pc4);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit rnd, input bit f_redir, input logic [31:0] f_pc);
    logic [31:0] n_pc;
    int sel;
    if (rnd) begin
      if ($urandom_range(0, 2) == 0) stall = ~stall;
      redirect = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      redirect_pc = (sel == 0) ? 32'hFFFF_FFFC : (sel == 1) ? 32'h0000_0103 :
                    (sel == 2) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
    end else begin
      stall = 1'b0;
      redirect = f_redir;
      redirect_pc = f_pc;
    end
    if (mem_pending && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = !mem_pending && (!rnd || $urandom_range(0, 3) != 0);
    #1;
    exp_req = m_started && !m_busy && !m_drop && !redirect && (!m_valid || !stall);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("imem_addr", imem_addr, m_pc);

    // Model the rising edge.
    n_pc = m_pc;
    if (m_busy && imem_rvalid && !redirect) begin
      m_ins = imem_rdata; m_pco = m_reqpc; m_pc4 = m_reqpc + 32'd4;
      m_valid = 1'b1; m_busy = 1'b0; n_pc = m_pc + 32'd4;
      $display("[TB] fetch pc=%h ins=%h", m_reqpc, imem_rdata);
    end else if (redirect || (m_valid && !stall)) begin
      m_valid = 1'b0; m_ins = NOP;
    end
    if (m_drop && imem_rvalid) m_drop = 1'b0;
    if (redirect) begin
      n_pc = redirect_pc & ~32'd3;
      if (m_busy) begin
        m_busy = 1'b0;
        m_drop = !imem_rvalid;
      end
    end
    if (exp_req && imem_gnt) begin
      m_busy = 1'b1;
      m_reqpc = m_pc;
    end
    // Memory side.
    if (imem_rvalid) mem_pending = 1'b0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (exp_req && imem_gnt) begin
      mem_pending = 1'b1;
      mem_addr = m_pc;
      mem_cnt = ((mem_lat == 0) ? $urandom_range(1, 3) : mem_lat) - 1;
    end
    m_pc = n_pc;
    m_started = 1'b1;

    @(posedge clk); #1;
    check_regs("reg");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting mid-cycle; memory is frozen meanwhile.
  task automatic reset_pulse();
    #2;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    check("async_rst_req", {31'b0, imem_req}, 32'd0);
    check("async_rst_addr", imem_addr, RST_PC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_pending = 1'b0; mem_cnt = 0; mem_addr = '0; mem_lat = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset_req", {31'b0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, RST_PC);
    rst = 1'b1;

    // First fetch with a 1-cycle memory.
    repeat (8) cycle(0, 0, 0);

    // Random traffic.
    mem_lat = 0;
    repeat (600) cycle(1, 0, 0);

    // Fetch at the top of the address space.
    mem_lat = 1;
    cycle(0, 1, 32'hFFFF_FFFC);
    repeat (6) cycle(0, 0, 0);

    // Redirect to an unaligned target while a slow read is in flight.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_busy && mem_pending && mem_cnt > 0) found = 1'b1;
      else cycle(0, 0, 0);
    end
    check("reach_wait_redir", {31'b0, found}, 32'd1);
    cycle(0, 1, 32'h0000_0103);
    repeat (10) cycle(0, 0, 0);

    // Redirect coinciding with the response.
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_busy && mem_pending && mem_cnt == 0) found = 1'b1;
      else cycle(0, 0, 0);
    end
    check("reach_rvalid", {31'b0, found}, 32'd1);
    cycle(0, 1, 32'h0000_0240);
    repeat (6) cycle(0, 0, 0);

    // Reset while a read is outstanding; its late response must be ignored.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_busy && mem_pending && mem_cnt > 0) found = 1'b1;
      else cycle(0, 0, 0);
    end
    check("reach_wait_rst", {31'b0, found}, 32'd1);
    reset_pulse();
    repeat (12) cycle(0, 0, 0);

    // More random traffic with occasional resets.
    mem_lat = 0;
    for (int k = 0; k < 4; k++) begin
      repeat (200) cycle(1, 0, 0);
      reset_pulse();
    end
    repeat (100) cycle(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the instruction width.
REQ-002 Parameter PC_WIDTH SHALL default to 32 and set the address width.
REQ-003 Parameter RESET_PC SHALL default to 0 and set the first fetch address.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low; state clears immediately when rst=0.
REQ-006 stall  input  1  hold request from the hazard unit (IF_ID en = !stall).
REQ-007 redirect  input  1  taken branch or jump from EX.
REQ-008 redirect_pc  input  PC_WIDTH  target address for redirect.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  PC_WIDTH  request address; equals the current pc.
REQ-011 imem_gnt  input  1  memory accepts a request in the cycle imem_req=1.
REQ-012 imem_rvalid  input  1  read data valid.
REQ-013 imem_rdata  input  DATA_WIDTH  fetched instruction.
REQ-014 ins_out, pc_out, pc_plus4_out  output  DATA_WIDTH/PC_WIDTH/PC_WIDTH  registered fetch result, driving IF_ID ins_in/pc_in/pc_plus4_in.
REQ-015 valid_out  output  1  the output buffer holds a real instruction.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and DRAIN; reset enters IDLE, and IDLE goes to REQ unconditionally after one cycle.
REQ-017 In REQ, imem_req SHALL be 1 only when redirect=0 and the buffer is free (valid_out=0, or valid_out=1 with stall=0).
REQ-018 In REQ, imem_req=1 with imem_gnt=1 SHALL latch the request pc and move to WAIT; otherwise the FSM stays in REQ.
REQ-019 At most one request SHALL be outstanding.
REQ-020 In WAIT, imem_rvalid=1 with redirect=0 SHALL load ins_out=imem_rdata, pc_out=latched pc, pc_plus4_out=latched pc+4 and valid_out=1, advance pc by 4 and return to REQ.
REQ-021 Response latency: valid_out SHALL rise on the cycle after imem_rvalid; peak throughput is one instruction per two cycles with a 1-cycle memory.
REQ-022 The buffer SHALL be consumed on any cycle with valid_out=1 and stall=0; with no new response on that cycle, valid_out SHALL clear.
REQ-023 While stall=1, all outputs SHALL hold their values.
REQ-024 While valid_out=0, ins_out SHALL read NOP 32'h00000013.
REQ-025 redirect=1 SHALL load pc with redirect_pc with bits[1:0] forced to 0, clear valid_out, and take priority over stall.
REQ-026 A redirect in WAIT with imem_rvalid=0 SHALL move the FSM to DRAIN.
REQ-027 A redirect in WAIT with imem_rvalid=1 in the same cycle SHALL discard the response and move the FSM to REQ.
REQ-028 In DRAIN, the next imem_rvalid SHALL be discarded and the FSM SHALL move to REQ; a redirect in DRAIN updates pc and the FSM stays in DRAIN.
REQ-029 pc+4 SHALL wrap modulo 2^PC_WIDTH.

Reset
REQ-030 While rst=0: pc=RESET_PC, state IDLE, valid_out=0, ins_out=NOP, pc_out=0, pc_plus4_out=0 and imem_req=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_rvalid after reset release SHALL be ignored, because the FSM is in IDLE or REQ.

Structure
REQ-032 Package if_pkg SHALL hold the FSM state enum, the NOP constant and the default RESET_PC.
REQ-033 The FSM and output buffer SHALL live in if_stage; the pc register with its redirect/increment mux MAY be the single sub-module if_pc_reg.

Verification
REQ-034 Reset release with RESET_PC=0 and a 1-cycle memory returning 0x00500093 -> imem_req asserts 1 cycle after reset release, with imem_addr=0; then ins_out=0x00500093, pc_out=0, pc_plus4_out=4, valid_out=1.
REQ-035 stall=1 for 3 cycles while valid_out=1 -> outputs are constant and imem_req stays 0 until stall drops.
REQ-036 redirect=1 with redirect_pc=0x00000103 during WAIT, rvalid 2 cycles later -> that response is dropped, the next imem_addr is 0x00000100, and valid_out is 0 until the new response arrives.
REQ-037 redirect and imem_rvalid in the same cycle -> the response is discarded and the next request goes to the target.
REQ-038 pc=0xFFFFFFFC fetched -> pc_plus4_out=0, and the next imem_addr is 0.
REQ-039 rst=0 asserted in WAIT, imem_rvalid pulsed after release -> valid_out stays 0, and the first request is to RESET_PC.
